// File: rtl/itr_pkg.sv
// Shared constants and helpers for the nestable priority interrupt controller.
package itr_pkg;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   localparam int VEC_BASE_DEF   = 150;
   localparam int VEC_STRIDE_DEF = 10;

   function automatic int unsigned vec_addr(
      input int unsigned base,
      input int unsigned stride,
      input int unsigned idx
   );
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/pri_encoder_n.sv
// Lowest-index-first priority encoder with a valid flag.
module pri_encoder_n #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] vec,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   always_comb begin
      idx   = '0;
      valid = |vec;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/itr_ctrl_n.sv
// Maskable, vectored, nestable interrupt controller; index 0 is the highest
// priority, and only strictly higher priorities preempt an in-service level.
module itr_ctrl_n
   import itr_pkg::*;
#(
   parameter int NUM_SRC    = 8,
   parameter int ADDR_W     = 8,
   parameter int VEC_BASE   = VEC_BASE_DEF,
   parameter int VEC_STRIDE = VEC_STRIDE_DEF,
   parameter int ID_W       = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NUM_SRC-1:0] itr_in,
   input  logic               itr_en,
   input  logic               itr_clr,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_in,
   input  logic               itr_ack,
   input  logic               itr_ret,
   output logic               i_pending,
   output logic [ADDR_W-1:0]  PC_out,
   output logic [ID_W-1:0]    itr_id,
   output logic [NUM_SRC-1:0] ITR_register,
   output logic [NUM_SRC-1:0] MASK_register,
   output logic [NUM_SRC-1:0] ISR_register
);

   logic [NUM_SRC-1:0] prev_q, pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d, isr_q, isr_d;
   logic [NUM_SRC-1:0] cand, rise;
   logic [0:0]         state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d, best, isr_top;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               best_v, isr_v, elig;

   assign cand = pend_q & mask_q;
   assign rise = itr_in & ~prev_q;

   pri_encoder_n #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_cand_enc (
      .vec   (cand),
      .idx   (best),
      .valid (best_v)
   );

   pri_encoder_n #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_isr_enc (
      .vec   (isr_q),
      .idx   (isr_top),
      .valid (isr_v)
   );

   assign elig = best_v && (!isr_v || best < isr_top);

   always_comb begin
      pend_d  = pend_q;
      mask_d  = mask_q;
      isr_d   = isr_q;
      state_d = state_q;
      id_d    = id_q;
      pc_d    = pc_q;
      if (itr_clr) begin
         pend_d  = '0;
         isr_d   = '0;
         state_d = S_IDLE;
      end else begin
         // Return retires the current level before an ack can nest a new one.
         if (itr_ret && isr_v) isr_d[isr_top] = 1'b0;
         if (mask_we) mask_d = mask_in;
         if (state_q == S_IDLE) begin
            if (elig && itr_en) begin
               state_d = S_REQ;
               id_d    = best;
               pc_d    = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(best)));
            end
         end else begin
            if (itr_ack) begin
               pend_d[id_q] = 1'b0;
               isr_d[id_q]  = 1'b1;
               state_d      = S_IDLE;
            end else if (!itr_en) begin
               state_d = S_IDLE;
            end
         end
         pend_d = pend_d | rise;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         isr_q   <= '0;
         state_q <= S_IDLE;
         id_q    <= '0;
         pc_q    <= ADDR_W'(VEC_BASE);
      end else begin
         prev_q  <= itr_in;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         isr_q   <= isr_d;
         state_q <= state_d;
         id_q    <= id_d;
         pc_q    <= pc_d;
      end
   end

   assign i_pending     = (state_q == S_REQ);
   assign PC_out        = pc_q;
   assign itr_id        = id_q;
   assign ITR_register  = pend_q;
   assign MASK_register = mask_q;
   assign ISR_register  = isr_q;

endmodule

// File: tb/tb_itr_ctrl_n.sv
// Scoreboard bench for itr_ctrl_n: presentations are checked by a monitor.
module tb_itr_ctrl_n;

   logic       clk = 1'b0;
   logic       clr, itr_en, itr_clr, mask_we, itr_ack, itr_ret;
   logic [7:0] itr_in, mask_in;
   logic       i_pending;
   logic [7:0] PC_out, ITR_register, MASK_register, ISR_register;
   logic [2:0] itr_id;

   typedef struct {
      int id;
      int pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic seen = 1'b0;

   always #5 clk = ~clk;

   itr_ctrl_n dut (
      .clk           (clk),
      .clr           (clr),
      .itr_in        (itr_in),
      .itr_en        (itr_en),
      .itr_clr       (itr_clr),
      .mask_we       (mask_we),
      .mask_in       (mask_in),
      .itr_ack       (itr_ack),
      .itr_ret       (itr_ret),
      .i_pending     (i_pending),
      .PC_out        (PC_out),
      .itr_id        (itr_id),
      .ITR_register  (ITR_register),
      .MASK_register (MASK_register),
      .ISR_register  (ISR_register)
   );

   initial begin
      forever begin
         @(negedge clk);
         if (i_pending === 1'b1 && !seen) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL present_unexpected id=%0d pc=%0d", itr_id, PC_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (int'(itr_id) != e.id || int'(PC_out) != e.pc) begin
                  errors++;
                  $display("FAIL present id=%0d pc=%0d want id=%0d pc=%0d",
                           itr_id, PC_out, e.id, e.pc);
               end
            end
         end
         seen = (i_pending === 1'b1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input int pc);
      exp_t e;
      e.id = id;
      e.pc = pc;
      exp_q.push_back(e);
   endtask

   task automatic pulse(input int src);
      itr_in[src] = 1'b1;
      step();
      itr_in = '0;
   endtask

   task automatic ack();
      itr_ack = 1'b1;
      step();
      itr_ack = 1'b0;
   endtask

   task automatic ret();
      itr_ret = 1'b1;
      step();
      itr_ret = 1'b0;
   endtask

   initial begin
      clr = 1'b0; itr_en = 1'b0; itr_clr = 1'b0; mask_we = 1'b0;
      itr_ack = 1'b0; itr_ret = 1'b0; itr_in = '0; mask_in = '0;
      step(); step();
      chk("rst_ipend", int'(i_pending), 0);
      chk("rst_pc", int'(PC_out), 150);
      chk("rst_id", int'(itr_id), 0);
      chk("rst_itr", int'(ITR_register), 0);
      chk("rst_mask", int'(MASK_register), 0);
      chk("rst_isr", int'(ISR_register), 0);
      clr = 1'b1;

      mask_we = 1'b1; mask_in = 8'hFF; step(); mask_we = 1'b0;
      chk("mask_ff", int'(MASK_register), 8'hFF);
      itr_en = 1'b1;

      // single source, two-cycle latency
      push(3, 180);
      pulse(3);
      chk("t1_itr", int'(ITR_register), 8'h08);
      chk("t1_ipend_early", int'(i_pending), 0);
      step();
      chk("t1_ipend", int'(i_pending), 1);
      ack();
      chk("t1_isr", int'(ISR_register), 8'h08);
      chk("t1_itr_clr", int'(ITR_register), 0);
      ret();
      chk("t1_ret", int'(ISR_register), 0);

      // simultaneous 5 and 2; 5 blocked by in-service 2
      push(2, 170);
      itr_in = 8'h24; step(); itr_in = '0;
      step();
      ack();
      chk("t2_isr", int'(ISR_register), 8'h04);
      chk("t2_itr", int'(ITR_register), 8'h20);
      step(); step(); step();
      chk("t2_blocked", int'(i_pending), 0);
      push(5, 200);
      ret();
      chk("t2_ret", int'(ISR_register), 0);
      step();
      chk("t2_ipend5", int'(i_pending), 1);
      ack();
      ret();

      // nesting 4 then 1
      push(4, 190);
      pulse(4); step();
      ack();
      chk("t3_isr4", int'(ISR_register), 8'h10);
      push(1, 160);
      pulse(1); step();
      chk("t3_pc1", int'(PC_out), 160);
      ack();
      chk("t3_isr12", int'(ISR_register), 8'h12);
      ret();
      chk("t3_ret", int'(ISR_register), 8'h10);
      ret();
      chk("t3_ret2", int'(ISR_register), 0);

      // masked request latched, presented once unmasked
      mask_we = 1'b1; mask_in = 8'hFE; step(); mask_we = 1'b0;
      pulse(0); step(); step();
      chk("t4_masked", int'(i_pending), 0);
      chk("t4_itr", int'(ITR_register), 8'h01);
      push(0, 150);
      mask_we = 1'b1; mask_in = 8'hFF; step(); mask_we = 1'b0;
      step();
      chk("t4_pc", int'(PC_out), 150);

      // enable drop in REQ, then itr_clr
      itr_en = 1'b0; step();
      chk("t5_ipend", int'(i_pending), 0);
      chk("t5_itr", int'(ITR_register), 8'h01);
      step();
      itr_clr = 1'b1; step(); itr_clr = 1'b0;
      chk("t5_clr_itr", int'(ITR_register), 0);
      chk("t5_clr_isr", int'(ISR_register), 0);
      chk("t5_clr_mask", int'(MASK_register), 8'hFF);
      itr_en = 1'b1;

      // level held high raises one request only
      push(6, 210);
      itr_in[6] = 1'b1;
      repeat (10) step();
      chk("t6_itr", int'(ITR_register), 8'h40);
      ack();
      chk("t6_itr_after", int'(ITR_register), 0);
      chk("t6_isr", int'(ISR_register), 8'h40);
      itr_in = '0; step();
      ret();
      chk("t6_ret", int'(ISR_register), 0);

      // fresh edge during ack of same source keeps it pending
      push(6, 210);
      pulse(6); step();
      itr_in[6] = 1'b1; itr_ack = 1'b1; step();
      itr_ack = 1'b0; itr_in = '0;
      chk("t7_itr", int'(ITR_register), 8'h40);
      chk("t7_isr", int'(ISR_register), 8'h40);
      step();
      chk("t7_blocked", int'(i_pending), 0);
      push(6, 210);
      ret(); step();
      chk("t7_ipend", int'(i_pending), 1);
      ack();
      ret();

      // ack outside REQ is ignored
      ack();
      chk("t8_isr", int'(ISR_register), 0);

      // ret and ack in the same cycle
      push(4, 190);
      pulse(4); step();
      ack();
      push(1, 160);
      pulse(1); step();
      itr_ret = 1'b1; itr_ack = 1'b1; step();
      itr_ret = 1'b0; itr_ack = 1'b0;
      chk("t9_isr", int'(ISR_register), 8'h02);
      ret();
      chk("t9_ret", int'(ISR_register), 0);

      // reset while in REQ
      push(3, 180);
      pulse(3); step();
      chk("t10_ipend", int'(i_pending), 1);
      clr = 1'b0; itr_ack = 1'b1; step(); itr_ack = 1'b0;
      chk("t10_isr", int'(ISR_register), 0);
      chk("t10_itr", int'(ITR_register), 0);
      chk("t10_mask", int'(MASK_register), 0);
      chk("t10_ipend0", int'(i_pending), 0);
      chk("t10_pc", int'(PC_out), 150);
      clr = 1'b1;

      step(); step(); step();
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/itr_ctrl_n.md
Name: itr_ctrl_n

Overview:
- Parametrised maskable, vectored, nestable priority interrupt controller for the accumulator processor.
- Supports NUM_SRC sources with per-source edge capture and a programmable mask register.
- Provides a fixed-priority vector table and an acknowledge/return handshake with the control unit.
- Tracks in-service levels, so only strictly higher-priority requests preempt a running ISR.

Parameters:
- NUM_SRC, 8: number of interrupt sources; index 0 has the highest priority.
- ADDR_W, 8: width of the ISR address (PC) output.
- VEC_BASE, 150: ISR address of source 0.
- VEC_STRIDE, 10: address spacing between consecutive source ISRs.
- ID_W, $clog2(NUM_SRC): width of the source index (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-low reset.
- itr_in  in  NUM_SRC  raw interrupt lines; a rising edge raises a request.
- itr_en  in  1  global enable; 0 forces i_pending low but still captures events.
- itr_clr  in  1  synchronous clear of pending and in-service state (active high).
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  NUM_SRC  new mask value; 1 = source enabled.
- itr_ack  in  1  control unit takes the presented vector.
- itr_ret  in  1  control unit executes return-from-interrupt.
- i_pending  out  1  a request is presented and awaiting ack.
- PC_out  out  ADDR_W  ISR address of the presented request.
- itr_id  out  ID_W  index of the presented request.
- ITR_register  out  NUM_SRC  pending register.
- MASK_register  out  NUM_SRC  mask register.
- ISR_register  out  NUM_SRC  in-service register.

Behaviour:
- Reset (clr=0 at a clock edge): pending, mask, in-service, and the edge-detect history are all 0. State is IDLE. i_pending=0, PC_out=VEC_BASE, itr_id=0.
- Edge capture: itr_in is registered each cycle. When itr_in[i] & ~prev[i], pending[i] sets at the next edge. Level-high with no edge raises nothing further.
- Mask: when mask_we=1, the mask loads mask_in at the edge. Masked pending bits stay latched and are presented once unmasked.
- Eligibility: cand = pending & mask. best = lowest set index of cand. best is eligible iff cand≠0 and (ISR_register=0 or best < lowest set index of ISR_register).
- FSM, IDLE: when best is eligible and itr_en=1, the next state is REQ. On that transition, itr_id<=best and PC_out<=VEC_BASE+best*VEC_STRIDE (mod 2^ADDR_W).
- FSM, REQ: i_pending=1; itr_id and PC_out stay frozen, even if a higher-priority request arrives.
  - itr_ack=1: pending[itr_id] clears, ISR_register[itr_id] sets, next state IDLE.
  - itr_en falling to 0 without ack: return to IDLE; pending is retained.
- In IDLE, i_pending=0 and PC_out/itr_id hold their last value.
- Latency: an edge sampled at edge t gives pending at t+1 and i_pending=1 after t+2. After an ack, the next eligible request presents 1 cycle later.
- itr_ret: clears the lowest-index set bit of ISR_register. With ISR_register=0, itr_ret is ignored.
- itr_ack outside REQ is ignored.
- Simultaneous itr_ret+itr_ack: the return applies first, then the ack sets the new in-service bit.
- New edge on source k in the same cycle as the ack clearing pending[k]: the set wins and the bit stays pending.
- itr_clr=1: pending and in-service clear, state goes to IDLE; mask and edge history are unaffected.
- clr has priority over itr_clr, which has priority over all other updates.
- Reset asserted mid-REQ: the full reset applies and no ack is recorded.

Decomposition:
- Package itr_pkg holds: the state enum (IDLE, REQ), default VEC_BASE/VEC_STRIDE constants, and the vector-address function.
- Sub-module pri_encoder_n(NUM_SRC): combinational lowest-index-first encoder with a valid flag. It is instantiated twice, once for cand and once for ISR_register.

Test Plan:
- Reset with NUM_SRC=8, mask=8'hFF; pulse itr_in[3] -> i_pending=1 two cycles later, itr_id=3, PC_out=180.
- Raise itr_in[5] and itr_in[2] in the same cycle -> itr_id=2, PC_out=170. Ack -> ISR_register=8'h04, then source 5 is not presented. itr_ret -> ISR_register=0, source 5 is presented with PC_out=200.
- Nesting: ack source 4; then pulse itr_in[1] -> presented with PC_out=160. Ack -> ISR_register=8'h12. itr_ret -> ISR_register=8'h10.
- Mask 8'hFE, pulse itr_in[0] -> i_pending stays 0 while ITR_register=8'h01. Write mask 8'hFF -> i_pending=1, PC_out=150.
- In REQ, drive itr_en=0 -> i_pending=0 next cycle with pending retained. itr_clr -> ITR_register=0, ISR_register=0.
- Hold itr_in[6] high for 10 cycles -> exactly one pending set. Ack in the same cycle as a fresh edge on the acked source -> that bit remains pending.
